// File: rtl/memory_cycle.sv
// MEM stage of the pipeline: drives a request/acknowledge data-memory bus, formats
// store lanes and load extraction, and owns the MEM/WB pipeline register.
module memory_cycle (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] InstrM,
   input  logic [31:0] AuLu_ResultM,
   input  logic [4:0]  RdM,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic [1:0]  ResultSrcM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUResultW,
   output logic [31:0] PCPlus4W,
   output logic [31:0] AuLu_ResultW,
   output logic [4:0]  RdW,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic        StallM,
   output logic        MisalignM,
   output logic        BusErrM
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [31:0] rdata_q;

   logic [2:0]  funct3;
   logic [1:0]  addr_lo;
   logic        is_access;
   logic        misalign_cond;
   logic        misaligned;
   logic        aligned;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_data;
   logic        drop_wb;
   logic        unused_bits;

   assign funct3      = InstrM[14:12];
   assign addr_lo     = ALUResultM[1:0];
   assign unused_bits = ^{InstrM[31:15], InstrM[11:0]};

   // Access classification and store lane formatting from the EX/MEM contents
   always_comb begin
      is_access     = MemWriteM | (ResultSrcM == 2'b01);
      misalign_cond = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
      misaligned    = is_access & misalign_cond;
      aligned       = is_access & ~misalign_cond;
      be_next       = 4'b1111;
      wdata_next    = WriteDataM;
      if (MemWriteM) begin
         case (funct3[1:0])
            2'b00: begin
               be_next    = 4'b0001 << addr_lo;
               wdata_next = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
               be_next    = 4'b0011 << addr_lo;
               wdata_next = {2{WriteDataM[15:0]}};
            end
            default: begin
               be_next    = 4'b1111;
               wdata_next = WriteDataM;
            end
         endcase
      end
   end

   // Load extraction works on the captured word; the instruction is still frozen in DONE
   always_comb begin
      case (addr_lo)
         2'b00:   lane_byte = rdata_q[7:0];
         2'b01:   lane_byte = rdata_q[15:8];
         2'b10:   lane_byte = rdata_q[23:16];
         default: lane_byte = rdata_q[31:24];
      endcase
      lane_half = addr_lo[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (funct3)
         3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
         3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
         3'b100:  load_data = {24'b0, lane_byte};
         3'b101:  load_data = {16'b0, lane_half};
         default: load_data = rdata_q;
      endcase
   end

   assign StallM   = ((state == IDLE) & aligned) | (state == REQ);
   assign dmem_req = (state == REQ);
   assign drop_wb  = ((state == IDLE) & misaligned) | ((state == DONE) & BusErrM);

   // Bus controller: request fields are latched on REQ entry so they cannot move until ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= 8'd0;
         rdata_q    <= 32'd0;
         dmem_addr  <= 32'd0;
         dmem_we    <= 1'b0;
         dmem_be    <= 4'd0;
         dmem_wdata <= 32'd0;
         MisalignM  <= 1'b0;
         BusErrM    <= 1'b0;
      end else begin
         MisalignM <= 1'b0;
         BusErrM   <= 1'b0;
         case (state)
            IDLE: begin
               if (aligned) begin
                  state      <= REQ;
                  wait_cnt   <= 8'd0;
                  dmem_addr  <= {ALUResultM[31:2], 2'b00};
                  dmem_we    <= MemWriteM;
                  dmem_be    <= be_next;
                  dmem_wdata <= wdata_next;
               end else if (misaligned) begin
                  MisalignM <= 1'b1;
               end
            end
            REQ: begin
               if (dmem_ack) begin
                  if (!dmem_we)
                     rdata_q <= dmem_rdata;
                  state <= DONE;
               end else if (wait_cnt == 8'd254) begin
                  wait_cnt <= 8'd255;
                  BusErrM  <= 1'b1;
                  state    <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // MEM/WB register: a stalled cycle inserts a bubble so writeback happens exactly once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ReadDataW    <= 32'd0;
         ALUResultW   <= 32'd0;
         PCPlus4W     <= 32'd0;
         AuLu_ResultW <= 32'd0;
         RdW          <= 5'd0;
         RegWriteW    <= 1'b0;
         ResultSrcW   <= 2'd0;
      end else if (StallM) begin
         RegWriteW  <= 1'b0;
         RdW        <= 5'd0;
         ResultSrcW <= 2'd0;
      end else begin
         ReadDataW    <= load_data;
         ALUResultW   <= ALUResultM;
         PCPlus4W     <= PCPlus4M;
         AuLu_ResultW <= AuLu_ResultM;
         RdW          <= RdM;
         RegWriteW    <= RegWriteM & ~drop_wb;
         ResultSrcW   <= ResultSrcM;
      end
   end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed self-checking bench for memory_cycle: ALU pass-through, loads, stores,
// misalignment, bus timeout and reset during an outstanding request.
module tb_memory_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M, InstrM, AuLu_ResultM;
   logic [4:0]  RdM;
   logic        RegWriteM, MemWriteM;
   logic [1:0]  ResultSrcM;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic [31:0] ReadDataW, ALUResultW, PCPlus4W, AuLu_ResultW;
   logic [4:0]  RdW;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic        StallM, MisalignM, BusErrM;

   int n_cmp = 0;
   int n_fail = 0;

   int          r_stall, r_req, r_regw, r_mis, r_berr, r_unstable;
   logic [31:0] r_rdata, r_addr, r_wdata;
   logic [4:0]  r_rd;
   logic        r_we;
   logic [3:0]  r_be;

   always #5 clk = ~clk;

   memory_cycle dut (
      .clk(clk), .rst(rst),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
      .InstrM(InstrM), .AuLu_ResultM(AuLu_ResultM), .RdM(RdM),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .ReadDataW(ReadDataW), .ALUResultW(ALUResultW),
      .PCPlus4W(PCPlus4W), .AuLu_ResultW(AuLu_ResultW), .RdW(RdW),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .StallM(StallM),
      .MisalignM(MisalignM), .BusErrM(BusErrM)
   );

   task automatic set_nop();
      ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0; InstrM = 0; AuLu_ResultM = 0;
      RdM = 0; RegWriteM = 0; MemWriteM = 0; ResultSrcM = 2'b00;
   endtask

   task automatic idle();
      set_nop();
      @(posedge clk); #1;
   endtask

   task automatic set_mem(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd);
      InstrM = {17'd0, f3, 12'h003};
      ALUResultM = addr; WriteDataM = wd; RdM = rd;
      MemWriteM = st; RegWriteM = ~st; ResultSrcM = st ? 2'b00 : 2'b01;
      PCPlus4M = 32'h40; AuLu_ResultM = 32'h0;
   endtask

   // Plays the memory side and the pipeline: ack on the ack_after-th REQ cycle (0 = never)
   task automatic run_access(input int ack_after, input int max_cycles);
      logic stall_now;
      r_stall = 0; r_req = 0; r_regw = 0; r_mis = 0; r_berr = 0; r_unstable = 0;
      r_rdata = 0; r_rd = 0; r_addr = 0; r_wdata = 0; r_we = 0; r_be = 0;
      for (int c = 0; c < max_cycles; c++) begin
         @(negedge clk);
         if (StallM) r_stall++;
         if (RegWriteW) begin r_regw++; r_rdata = ReadDataW; r_rd = RdW; end
         if (MisalignM) r_mis++;
         if (BusErrM) r_berr++;
         if (dmem_req) begin
            if (r_req == 0) begin
               r_addr = dmem_addr; r_we = dmem_we; r_be = dmem_be; r_wdata = dmem_wdata;
            end else if (dmem_addr !== r_addr || dmem_we !== r_we ||
                         dmem_be !== r_be || dmem_wdata !== r_wdata) begin
               r_unstable++;
            end
            r_req++;
            dmem_ack = (ack_after != 0) && (r_req == ack_after);
         end else begin
            dmem_ack = 1'b0;
         end
         stall_now = StallM;
         @(posedge clk); #1;
         if (!stall_now) set_nop();
      end
      dmem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 0; set_nop();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b want 0", dmem_req); end
      n_cmp++; if ({RegWriteW, RdW, ResultSrcW} !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_wb_ctrl: got %h want 0", {RegWriteW, RdW, ResultSrcW}); end
      n_cmp++; if ({ReadDataW, ALUResultW} !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_wb_data: got %h want 0", {ReadDataW, ALUResultW}); end
      n_cmp++; if ({MisalignM, BusErrM, StallM} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 000", {MisalignM, BusErrM, StallM}); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_alu();
      idle();
      RegWriteM = 1; RdM = 5; ALUResultM = 32'h1234; PCPlus4M = 32'h88; AuLu_ResultM = 32'h99;
      dmem_ack = 1'b1;
      @(negedge clk);
      n_cmp++; if (StallM !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_stall: got %b want 0", StallM); end
      @(posedge clk); #1; set_nop(); dmem_ack = 1'b0;
      @(negedge clk);
      n_cmp++; if (RdW !== 5'd5) begin n_fail++; $display("[TB] FAIL alu_rd: got %0d want 5", RdW); end
      n_cmp++; if (ALUResultW !== 32'h1234) begin n_fail++; $display("[TB] FAIL alu_result: got %h want 00001234", ALUResultW); end
      n_cmp++; if (RegWriteW !== 1'b1) begin n_fail++; $display("[TB] FAIL alu_regwrite: got %b want 1", RegWriteW); end
      n_cmp++; if ({PCPlus4W, AuLu_ResultW} !== {32'h88, 32'h99}) begin n_fail++; $display("[TB] FAIL alu_pc_aulu: got %h want 0000008800000099", {PCPlus4W, AuLu_ResultW}); end
      n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_ack_ignored: got %b want 0", dmem_req); end
   endtask

   task automatic test_back_to_back();
      idle();
      RegWriteM = 1; RdM = 1; ALUResultM = 32'h11;
      @(posedge clk); #1;
      RdM = 2; ALUResultM = 32'h22;
      @(negedge clk);
      n_cmp++; if ({RdW, ALUResultW} !== {5'd1, 32'h11}) begin n_fail++; $display("[TB] FAIL b2b_first: got %h want %h", {RdW, ALUResultW}, {5'd1, 32'h11}); end
      @(posedge clk); #1; set_nop();
      @(negedge clk);
      n_cmp++; if ({RdW, ALUResultW} !== {5'd2, 32'h22}) begin n_fail++; $display("[TB] FAIL b2b_second: got %h want %h", {RdW, ALUResultW}, {5'd2, 32'h22}); end
   endtask

   task automatic test_load_byte();
      idle();
      set_mem(1'b0, 3'b000, 32'h103, 32'h0, 5'd7);
      dmem_rdata = 32'h80FFFFFF;
      run_access(2, 8);
      n_cmp++; if (r_stall !== 3) begin n_fail++; $display("[TB] FAIL lb_stall_cycles: got %0d want 3", r_stall); end
      n_cmp++; if (r_req !== 2) begin n_fail++; $display("[TB] FAIL lb_req_cycles: got %0d want 2", r_req); end
      n_cmp++; if (r_regw !== 1) begin n_fail++; $display("[TB] FAIL lb_regwrite_count: got %0d want 1", r_regw); end
      n_cmp++; if (r_rdata !== 32'hFFFFFF80) begin n_fail++; $display("[TB] FAIL lb_data: got %h want ffffff80", r_rdata); end
      n_cmp++; if (r_rd !== 5'd7) begin n_fail++; $display("[TB] FAIL lb_rd: got %0d want 7", r_rd); end
      n_cmp++; if ({r_addr, r_we, r_be} !== {32'h100, 1'b0, 4'b1111}) begin n_fail++; $display("[TB] FAIL lb_bus: got %h want %h", {r_addr, r_we, r_be}, {32'h100, 1'b0, 4'b1111}); end
   endtask

   task automatic test_load_half();
      idle();
      set_mem(1'b0, 3'b001, 32'h102, 32'h0, 5'd8);
      dmem_rdata = 32'h80011234;
      run_access(1, 6);
      n_cmp++; if (r_rdata !== 32'hFFFF8001) begin n_fail++; $display("[TB] FAIL lh_data: got %h want ffff8001", r_rdata); end
      n_cmp++; if (r_stall !== 2) begin n_fail++; $display("[TB] FAIL lh_stall_cycles: got %0d want 2", r_stall); end
      idle();
      set_mem(1'b0, 3'b101, 32'h102, 32'h0, 5'd8);
      run_access(1, 6);
      n_cmp++; if (r_rdata !== 32'h00008001) begin n_fail++; $display("[TB] FAIL lhu_data: got %h want 00008001", r_rdata); end
   endtask

   task automatic test_stores();
      idle();
      set_mem(1'b1, 3'b001, 32'h102, 32'hABCD, 5'd0);
      run_access(1, 6);
      n_cmp++; if (r_be !== 4'b1100) begin n_fail++; $display("[TB] FAIL sh_be: got %b want 1100", r_be); end
      n_cmp++; if (r_wdata !== 32'hABCDABCD) begin n_fail++; $display("[TB] FAIL sh_wdata: got %h want abcdabcd", r_wdata); end
      n_cmp++; if ({r_we, r_addr} !== {1'b1, 32'h100}) begin n_fail++; $display("[TB] FAIL sh_we_addr: got %h want 100000100", {r_we, r_addr}); end
      n_cmp++; if (r_regw !== 0) begin n_fail++; $display("[TB] FAIL sh_regwrite: got %0d want 0", r_regw); end
      idle();
      set_mem(1'b1, 3'b000, 32'h101, 32'h1234565A, 5'd0);
      run_access(1, 6);
      n_cmp++; if ({r_be, r_wdata} !== {4'b0010, 32'h5A5A5A5A}) begin n_fail++; $display("[TB] FAIL sb_lane: got %h want 25a5a5a5a", {r_be, r_wdata}); end
      idle();
      set_mem(1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 5'd0);
      run_access(1, 6);
      n_cmp++; if ({r_be, r_wdata, r_addr} !== {4'b1111, 32'hDEADBEEF, 32'h200}) begin n_fail++; $display("[TB] FAIL sw_bus: got %h want fdeadbeef00000200", {r_be, r_wdata, r_addr}); end
   endtask

   task automatic test_misalign();
      idle();
      set_mem(1'b0, 3'b010, 32'h101, 32'h0, 5'd3);
      run_access(1, 4);
      n_cmp++; if (r_req !== 0) begin n_fail++; $display("[TB] FAIL lw_mis_req: got %0d want 0", r_req); end
      n_cmp++; if (r_mis !== 1) begin n_fail++; $display("[TB] FAIL lw_mis_pulse: got %0d want 1", r_mis); end
      n_cmp++; if ({r_regw, r_stall} !== {0, 0}) begin n_fail++; $display("[TB] FAIL lw_mis_wb_stall: got %0d/%0d want 0/0", r_regw, r_stall); end
      idle();
      set_mem(1'b1, 3'b001, 32'h103, 32'h5555, 5'd0);
      run_access(1, 4);
      n_cmp++; if ({r_req, r_mis} !== {0, 1}) begin n_fail++; $display("[TB] FAIL sh_mis: got req %0d pulse %0d want 0 1", r_req, r_mis); end
   endtask

   task automatic test_timeout();
      idle();
      set_mem(1'b0, 3'b010, 32'h300, 32'h0, 5'd4);
      run_access(0, 262);
      n_cmp++; if (r_req !== 255) begin n_fail++; $display("[TB] FAIL to_req_cycles: got %0d want 255", r_req); end
      n_cmp++; if (r_berr !== 1) begin n_fail++; $display("[TB] FAIL to_buserr_pulse: got %0d want 1", r_berr); end
      n_cmp++; if (r_regw !== 0) begin n_fail++; $display("[TB] FAIL to_regwrite: got %0d want 0", r_regw); end
      n_cmp++; if (r_stall !== 256) begin n_fail++; $display("[TB] FAIL to_stall_cycles: got %0d want 256", r_stall); end
      n_cmp++; if (r_unstable !== 0) begin n_fail++; $display("[TB] FAIL to_bus_stable: got %0d changes want 0", r_unstable); end
      @(negedge clk);
      n_cmp++; if ({dmem_req, StallM} !== 2'b00) begin n_fail++; $display("[TB] FAIL to_back_idle: got %b want 00", {dmem_req, StallM}); end
   endtask

   task automatic test_reset_mid();
      idle();
      set_mem(1'b0, 3'b010, 32'h0, 32'h0, 5'd9);
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (dmem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_req_up: got %b want 1", dmem_req); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_req_async_drop: got %b want 0", dmem_req); end
      n_cmp++; if ({RegWriteW, RdW, BusErrM} !== 7'd0) begin n_fail++; $display("[TB] FAIL mid_outputs: got %h want 0", {RegWriteW, RdW, BusErrM}); end
      set_nop();
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      set_mem(1'b0, 3'b100, 32'h0, 32'h0, 5'd10);
      dmem_rdata = 32'h000000FF;
      run_access(1, 6);
      n_cmp++; if ({r_regw, r_rdata} !== {1, 32'h000000FF}) begin n_fail++; $display("[TB] FAIL mid_lbu: got %0d/%h want 1/000000ff", r_regw, r_rdata); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_back_to_back();
      test_load_byte();
      test_load_half();
      test_stores();
      test_misalign();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
